// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_pkg: AES S-box tables, round constants, FSM states, GF(2^8) helpers.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ADDKEY = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } aes_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r of the column-major state rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = INV_SBOX[s[127-8*n -: 8]];
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_mix_column.sv
// +--------------------------------------------------------------------------+
// | aes_inv_mix_column: combinational InvMixColumns on one 32-bit column.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
  assign col_out[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
  assign col_out[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
  assign col_out[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

`default_nettype wire

// File: rtl/aes_decrypt_core.sv
// +--------------------------------------------------------------------------+
// | aes_decrypt_core: iterative AES-128 decryption, one round per clock.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_ENC,
  output logic [127:0] AES_MSG_DEC,
  output logic         AES_DONE
);

  aes_state_t   fsm;
  logic [3:0]   cnt;
  logic [127:0] blk;
  logic [127:0] rk [11];

  logic [127:0] rk_cur;
  logic [127:0] rk_next;
  logic [127:0] unsub;
  logic [127:0] rnd_in;
  logic [127:0] rnd_out;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  tmp;
  logic [31:0]  n0, n1, n2, n3;

  assign rk_cur = rk[cnt];

  // Key expansion step: cnt holds i-1 while rk[i] is being built.
  assign w0 = rk_cur[127:96];
  assign w1 = rk_cur[95:64];
  assign w2 = rk_cur[63:32];
  assign w3 = rk_cur[31:0];
  assign tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(cnt + 4'd1), 24'h000000};
  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign unsub  = inv_sub_bytes(inv_shift_rows(blk));
  assign rnd_in = unsub ^ rk_cur;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mix_column u_mix (
      .col_in  (rnd_in[127-32*c -: 32]),
      .col_out (rnd_out[127-32*c -: 32])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm         <= IDLE;
      cnt         <= 4'd0;
      blk         <= '0;
      AES_MSG_DEC <= '0;
      AES_DONE    <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (AES_START) begin
            rk[0] <= AES_KEY;
            blk   <= AES_MSG_ENC;
            cnt   <= 4'd0;
            fsm   <= KEYEXP;
          end
        end
        KEYEXP: begin
          if (!AES_START) begin
            fsm <= IDLE;
          end else begin
            rk[cnt + 4'd1] <= rk_next;
            cnt            <= cnt + 4'd1;
            if (cnt == 4'd9) fsm <= ADDKEY;
          end
        end
        ADDKEY: begin
          if (!AES_START) begin
            fsm <= IDLE;
          end else begin
            blk <= blk ^ rk[10];
            cnt <= 4'd9;
            fsm <= ROUND;
          end
        end
        ROUND: begin
          if (!AES_START) begin
            fsm <= IDLE;
          end else begin
            blk <= rnd_out;
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) fsm <= FINAL;
          end
        end
        FINAL: begin
          if (!AES_START) begin
            fsm <= IDLE;
          end else begin
            AES_MSG_DEC <= unsub ^ rk[0];
            AES_DONE    <= 1'b1;
            fsm         <= DONE;
          end
        end
        DONE: begin
          // Held until software clears Start, so a level-high Start never retriggers.
          if (!AES_START) begin
            AES_DONE <= 1'b0;
            fsm      <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
// +--------------------------------------------------------------------------+
// | tb_aes_decrypt_core: scoreboard bench with FIPS-197 directed vectors.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_aes_decrypt_core;
  import aes_pkg::*;

  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] E_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         AES_START = 1'b0;
  logic [127:0] AES_KEY = '0;
  logic [127:0] AES_MSG_ENC = '0;
  logic [127:0] AES_MSG_DEC;
  logic         AES_DONE;

  typedef struct {
    logic [127:0] dec;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  logic done_q = 1'b0;

  aes_decrypt_core dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .AES_START   (AES_START),
    .AES_KEY     (AES_KEY),
    .AES_MSG_ENC (AES_MSG_ENC),
    .AES_MSG_DEC (AES_MSG_DEC),
    .AES_DONE    (AES_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every rising AES_DONE must match the oldest outstanding run.
  always @(negedge CLK) begin
    exp_t e;
    if (AES_DONE === 1'b1 && done_q !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {127'b0, AES_DONE}, 128'd0);
      end else begin
        e = sb.pop_front();
        check("plaintext", AES_MSG_DEC, e.dec);
        check("latency", 128'(cyc), 128'(e.cyc));
      end
    end
    done_q = AES_DONE;
  end

  task automatic start_run(input logic [127:0] key, input logic [127:0] enc,
                           input bit push, input logic [127:0] exp_dec);
    exp_t e;
    @(negedge CLK);
    AES_KEY     = key;
    AES_MSG_ENC = enc;
    AES_START   = 1'b1;
    if (push) begin
      e.dec = exp_dec;
      e.cyc = cyc + 22;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (AES_DONE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (AES_DONE !== 1'b1) check("done_timeout", {127'b0, AES_DONE}, 128'd1);
  endtask

  task automatic finish_run();
    AES_START = 1'b0;
    @(negedge CLK);
    check("done_clear", {127'b0, AES_DONE}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(negedge CLK);
    check("reset_dec", AES_MSG_DEC, 128'd0);
    check("reset_done", {127'b0, AES_DONE}, 128'd0);
    RESET_N = 1'b1;

    start_run(K_C1, E_C1, 1'b1, P_C1);
    wait_done();
    finish_run();

    start_run(K_B, E_B, 1'b1, P_B);
    wait_done();
    check("rk10_appb", dut.rk[10], RK10_B);

    bad = 0;
    repeat (50) begin
      @(negedge CLK);
      if (AES_DONE !== 1'b1) bad++;
    end
    check("done_held", 128'(bad), 128'd0);
    finish_run();
    check("dec_after_release", AES_MSG_DEC, P_B);

    start_run(K_C1, E_C1, 1'b0, '0);
    repeat (12) @(negedge CLK);
    AES_START = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge CLK);
      if (AES_DONE !== 1'b0) bad++;
    end
    check("abort_no_done", 128'(bad), 128'd0);
    check("abort_dec_kept", AES_MSG_DEC, P_B);

    start_run(K_C1, E_C1, 1'b1, P_C1);
    wait_done();
    finish_run();

    start_run(K_C1, E_C1, 1'b1, P_C1);
    repeat (3) @(negedge CLK);
    AES_KEY     = '1;
    AES_MSG_ENC = '1;
    wait_done();
    finish_run();

    start_run(K_B, E_B, 1'b0, '0);
    repeat (15) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_done", {127'b0, AES_DONE}, 128'd0);
    check("rst_dec", AES_MSG_DEC, 128'd0);
    check("rst_fsm", 128'(dut.fsm), 128'(IDLE));
    AES_START = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;

    start_run(K_C1, E_C1, 1'b1, P_C1);
    wait_done();
    finish_run();

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
